// File: rtl/temporal_pkg.sv
// Shared types and sizing helpers for the race-logic temporal encoder.
package temporal_pkg;

  localparam int unsigned TENC_GCW   = 16;
  localparam int unsigned TENC_PW    = 8;
  localparam int unsigned TENC_NCH   = 2;
  localparam int unsigned TENC_VAL_W = $clog2(TENC_GCW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tenc_state_e;

  typedef logic [TENC_VAL_W-1:0] phase_t;
  typedef logic [TENC_VAL_W-1:0] val_t;

  // Largest value whose pulse still falls before the next gamma_rst.
  function automatic int unsigned max_val(input int unsigned gcw, input int unsigned pw);
    return gcw - 1 - pw;
  endfunction

endpackage

// File: rtl/temporal_encoder_gamma_phase_counter.sv
// Gamma-cycle phase counter: phase register, last-phase/wrap strobes and gamma_rst.
module gamma_phase_counter #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned VAL_W             = 4
) (
  input  logic             aclk,
  input  logic             grst_n,
  input  logic             in_cycle,
  input  logic             advance,
  input  logic             run_next,
  output logic [VAL_W-1:0] phase,
  output logic [VAL_W-1:0] phase_next_c,
  output logic             last_phase_c,
  output logic             wrap_c
);

  localparam logic [VAL_W-1:0] LAST_PHASE = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  logic gamma_rst_q;

  // Phase only advances while the cycle continues; otherwise it parks at 0.
  always_comb begin
    last_phase_c = (phase == LAST_PHASE);
    wrap_c       = in_cycle & last_phase_c;
    phase_next_c = '0;
    if (advance && !last_phase_c) begin
      phase_next_c = phase + VAL_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      phase       <= '0;
      gamma_rst_q <= 1'b0;
    end else begin
      phase       <= phase_next_c;
      gamma_rst_q <= run_next & (phase_next_c == '0);
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-race-logic spike encoder with gamma-cycle control.
// Optional TENC_COUNT_EN build adds a 32-bit completed-gamma-cycle counter.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = TENC_GCW,
  parameter int unsigned PULSE_WIDTH       = TENC_PW,
  parameter int unsigned NUM_CH            = TENC_NCH
) (
  input  logic                                  aclk,
  input  logic                                  grst_n,
  input  logic                                  en,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_CH*$clog2(GAMMA_CYCLE_WIDTH)-1:0] in_val,
  input  logic [NUM_CH-1:0]                     in_null,
  output logic                                  gamma_rst,
  output logic [NUM_CH-1:0]                     spike,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0]  phase,
  output logic                                  busy,
  output logic                                  err_range,
  output logic [31:0]                           gamma_count
);

  localparam int unsigned VAL_W   = $clog2(GAMMA_CYCLE_WIDTH);
  localparam int unsigned MAX_VAL = max_val(GAMMA_CYCLE_WIDTH, PULSE_WIDTH);
  localparam int unsigned CMP_W   = VAL_W + 1;
  localparam int unsigned DATA_W  = NUM_CH * VAL_W;
  localparam logic [VAL_W-1:0] LAST_PHASE = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  tenc_state_e state_q, state_d;

  logic [DATA_W-1:0] next_val_q, next_val_d, act_val_q, act_val_d;
  logic [NUM_CH-1:0] next_null_q, next_null_d, act_null_q, act_null_d;
  logic              next_full_q, next_full_d;

  logic [VAL_W-1:0]  phase_next_c;
  logic              last_phase_c, wrap_c;
  logic              in_cycle_c, advance_c, run_next_c;
  logic              xfer_c, promote_c, range_hit_c, in_ready_d;
  logic [NUM_CH-1:0] over_c, ld_null_c, spike_d;

  gamma_phase_counter #(
    .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
    .VAL_W             (VAL_W)
  ) u_phase (
    .aclk         (aclk),
    .grst_n       (grst_n),
    .in_cycle     (in_cycle_c),
    .advance      (advance_c),
    .run_next     (run_next_c),
    .phase        (phase),
    .phase_next_c (phase_next_c),
    .last_phase_c (last_phase_c),
    .wrap_c       (wrap_c)
  );

  assign gamma_rst = u_phase.gamma_rst_q;

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Stopping at phase 0 or at the last phase needs no drain: no cycle is left in flight.
  always_comb begin
    state_d    = state_q;
    in_cycle_c = 1'b0;
    advance_c  = 1'b0;
    run_next_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          if ((phase == '0) || last_phase_c) state_d = IDLE;
          else                               state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_phase_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_cycle_c = (state_q != IDLE);
    advance_c  = in_cycle_c & (state_d != IDLE);
    run_next_c = (state_d == RUN);
  end

  // Out-of-range values are stored as null so they can never spike late.
  always_comb begin
    over_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      over_c[i] = (in_val[i*VAL_W +: VAL_W] > VAL_W'(MAX_VAL));
    end
    ld_null_c   = in_null | over_c;
    range_hit_c = |(over_c & ~in_null);
  end

  // Holding/active registers; an empty holding register promotes as all-null.
  always_comb begin
    xfer_c      = in_valid & in_ready;
    promote_c   = wrap_c | ((state_q == IDLE) & (state_d == RUN));
    next_val_d  = next_val_q;
    next_null_d = next_null_q;
    next_full_d = next_full_q;
    act_val_d   = act_val_q;
    act_null_d  = act_null_q;
    if (promote_c) begin
      act_val_d   = next_val_q;
      act_null_d  = next_full_q ? next_null_q : '1;
      next_full_d = 1'b0;
    end
    if (xfer_c) begin
      next_val_d  = in_val;
      next_null_d = ld_null_c;
      next_full_d = 1'b1;
    end
    in_ready_d = !next_full_d | ((phase_next_c == LAST_PHASE) & (state_d != IDLE));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_spike
    logic [CMP_W-1:0] v_c, p_c;
    assign v_c = CMP_W'(act_val_d[g*VAL_W +: VAL_W]);
    assign p_c = CMP_W'(phase_next_c);
    assign spike_d[g] = (state_d != IDLE) & !act_null_d[g] &
                        (p_c >= v_c + CMP_W'(1)) &
                        (p_c <= v_c + CMP_W'(PULSE_WIDTH));
  end

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      next_val_q  <= '0;
      next_null_q <= '0;
      next_full_q <= 1'b0;
      act_val_q   <= '0;
      act_null_q  <= '1;
      in_ready    <= 1'b0;
      spike       <= '0;
      busy        <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      next_val_q  <= next_val_d;
      next_null_q <= next_null_d;
      next_full_q <= next_full_d;
      act_val_q   <= act_val_d;
      act_null_q  <= act_null_d;
      in_ready    <= in_ready_d;
      spike       <= spike_d;
      busy        <= (state_d != IDLE);
      if (xfer_c && range_hit_c) err_range <= 1'b1;
    end
  end

`ifdef TENC_COUNT_EN
  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n)     gamma_count <= '0;
    else if (wrap_c) gamma_count <= gamma_count + 32'd1;
  end
`else
  assign gamma_count = '0;
`endif

endmodule

// File: tb/tb_temporal_encoder.sv
// Scoreboard bench for temporal_encoder: per-gamma-cycle spike masks checked by a monitor.
module tb_temporal_encoder;

  logic        aclk = 1'b0;
  logic        grst_n = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_val = '0;
  logic [1:0]  in_null = '0;
  logic        gamma_rst;
  logic [1:0]  spike;
  logic [3:0]  phase;
  logic        busy;
  logic        err_range;
  logic [31:0] gamma_count;

`ifdef TENC_COUNT_EN
  localparam int EXP_GC = 6;
`else
  localparam int EXP_GC = 0;
`endif

  typedef struct {
    logic [15:0] m0;
    logic [15:0] m1;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   col = -1;
  int   gr_seen = 0;
  int   errors = 0;
  int   checks = 0;
  int   ph;

  temporal_encoder dut (
    .aclk        (aclk),
    .grst_n      (grst_n),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_val      (in_val),
    .in_null     (in_null),
    .gamma_rst   (gamma_rst),
    .spike       (spike),
    .phase       (phase),
    .busy        (busy),
    .err_range   (err_range),
    .gamma_count (gamma_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: gamma_rst opens a gamma cycle, then each phase is checked against the popped mask.
  always @(negedge aclk) begin
    if (!grst_n) begin
      col = -1;
    end else if (gamma_rst) begin
      gr_seen++;
      if (q.size() == 0) begin
        chk("unexpected_gamma_rst", 32'(q.size()), 32'd1);
        col = -1;
      end else begin
        cur = q.pop_front();
        col = 0;
      end
    end
    if (col >= 0) begin
      chk($sformatf("phase@%0d", col), 32'(phase), 32'(col));
      chk($sformatf("spike0@%0d", col), 32'(spike[0]), 32'(cur.m0[col]));
      chk($sformatf("spike1@%0d", col), 32'(spike[1]), 32'(cur.m1[col]));
      chk($sformatf("gamma_rst@%0d", col), 32'(gamma_rst), 32'(col == 0));
      col++;
      if (col == 16) col = -1;
    end else begin
      chk("spike_idle", 32'(spike), 32'd0);
    end
  end

  task automatic load(input logic [3:0] v0, input logic [3:0] v1, input logic [1:0] nul,
                      output int at_phase);
    int n;
    @(negedge aclk);
    in_valid = 1'b1;
    in_val   = {v1, v0};
    in_null  = nul;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 100) chk("load_timeout", 32'(n), 32'd0);
    at_phase = int'(phase);
    @(posedge aclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (int'(phase) != p && n < 200);
    if (n >= 200) chk("wait_phase_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    grst_n = 1'b1;
    @(negedge aclk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_phase", 32'(phase), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_gamma_rst", 32'(gamma_rst), 32'd0);
    chk("rel_err_range", 32'(err_range), 32'd0);
    chk("rel_gamma_count", gamma_count, 32'd0);

    // 1: v={0,7} -> ch0 phases 1-8, ch1 phases 8-15
    load(4'd0, 4'd7, 2'b00, ph);
    q.push_back('{m0: 16'h01FE, m1: 16'hFF00});
    @(negedge aclk);
    en = 1'b1;

    // 2: ch1 null, v0=3 -> ch0 phases 4-11; following cycle silent
    q.push_back('{m0: 16'h0FF0, m1: 16'h0000});
    load(4'd3, 4'd5, 2'b10, ph);
    q.push_back('{m0: 16'h0000, m1: 16'h0000});
    wait_phase(2);
    wait_phase(2);
    wait_phase(2);

    // 3: v0=8 out of range -> ch0 silent, err_range sticky; v1=2 -> phases 3-10
    chk("err_range_before", 32'(err_range), 32'd0);
    q.push_back('{m0: 16'h0000, m1: 16'h07F8});
    load(4'd8, 4'd2, 2'b00, ph);
    chk("err_range_set", 32'(err_range), 32'd1);

    // 4: back-to-back; second transfer accepted at the last phase
    wait_phase(2);
    q.push_back('{m0: 16'h03FC, m1: 16'h7F80});
    load(4'd1, 4'd6, 2'b00, ph);
    q.push_back('{m0: 16'h3FC0, m1: 16'h0000});
    load(4'd5, 4'd0, 2'b10, ph);
    chk("b2b_xfer_phase", 32'(ph), 32'd15);

    // 5: en dropped at phase 5 -> cycle completes, then IDLE
    wait_phase(5);
    wait_phase(5);
    en = 1'b0;
    wait_phase(15);
    chk("drain_busy", 32'(busy), 32'd1);
    @(negedge aclk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_phase", 32'(phase), 32'd0);
    chk("idle_gamma_rst", 32'(gamma_rst), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge aclk);
    chk("idle_no_gamma_rst", 32'(gr_seen), 32'd6);
    chk("idle_phase_held", 32'(phase), 32'd0);
    chk("err_range_sticky", 32'(err_range), 32'd1);
    chk("gamma_count", gamma_count, 32'(EXP_GC));

    // 6: async reset while ch0 is high
    q.push_back('{m0: 16'h07F8, m1: 16'h0000});
    load(4'd2, 4'd0, 2'b10, ph);
    @(negedge aclk);
    en = 1'b1;
    wait_phase(6);
    chk("pre_rst_spike0", 32'(spike[0]), 32'd1);
    en = 1'b0;
    #2 grst_n = 1'b0;
    #1;
    chk("async_spike", 32'(spike), 32'd0);
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge aclk);
    grst_n = 1'b1;
    @(negedge aclk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_phase", 32'(phase), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_err_range", 32'(err_range), 32'd0);
    chk("post_rst_gamma_count", gamma_count, 32'd0);
    repeat (20) @(negedge aclk);
    chk("post_rst_no_gamma_rst", 32'(gr_seen), 32'd7);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
